// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and leading-zero mask helper for the
//               seven-segment scan multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int              DIGITS           = 4;
    localparam int              NIB_W            = 4;
    localparam int              IDX_W            = 2;
    localparam logic [3:0]      ANODE_OFF        = 4'b1111;
    localparam int              TICK_DIV_DEF     = 100000;
    localparam int              BLANK_CYCLES_DEF = 1000;

    // Bit k set means digit k is a leading zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [DIGITS*NIB_W-1:0] active);
        logic [DIGITS-1:0] m;
        m    = '0;
        m[3] = (active[15:12] == 4'h0);
        m[2] = m[3] && (active[11:8] == 4'h0);
        m[1] = m[2] && (active[7:4]  == 4'h0);
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg_slot_timer
// Description : Digit-slot counter, digit index and frame boundary strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
    parameter int CNT_W        = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_slot_on,
    output logic             o_boundary
);

    localparam logic [CNT_W-1:0] c_last    = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_blank   = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_wrap;

    assign w_wrap = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Anodes stay off for the first BLANK_CYCLES of every slot.
    assign o_slot_on  = (r_cnt >= c_blank);
    assign o_boundary = w_wrap && (r_idx == c_idx_top);
    assign o_cnt      = r_cnt;
    assign o_idx      = r_idx;

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux
// Description : Four-digit time-multiplexed nibble/anode/dp driver with
//               leading-zero blanking and frame-aligned value updates.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        value_vld,
    input  logic [3:0]  dig_en,
    input  logic        lz_blank,
    input  logic [3:0]  dp_in,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);

    localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    generate
        if (TICK_DIV < 2 || BLANK_CYCLES >= TICK_DIV) begin : g_param_check
            $error("seg_scan_mux: need TICK_DIV >= 2 and BLANK_CYCLES < TICK_DIV");
        end
    endgenerate

    logic [c_cnt_w-1:0] w_cnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_slot_on;
    logic               w_boundary;

    seg_slot_timer #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (c_cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_cnt      (w_cnt),
        .o_idx      (w_idx),
        .o_slot_on  (w_slot_on),
        .o_boundary (w_boundary)
    );

    logic [15:0] r_active;
    logic [15:0] r_pending;
    logic        r_pend_flag;

    // active only ever moves on the frame boundary edge, so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_flag <= 1'b0;
        end else begin
            if (value_vld) begin
                r_pending <= value;
            end
            if (w_boundary) begin
                if (value_vld) begin
                    r_active <= value;
                end else if (r_pend_flag) begin
                    r_active <= r_pending;
                end
                r_pend_flag <= 1'b0;
            end else if (value_vld) begin
                r_pend_flag <= 1'b1;
            end
        end
    end

    logic [DIGITS-1:0] w_blank_mask;
    logic [DIGITS-1:0] w_dig_lit;
    logic [NIB_W-1:0]  w_dig_nib [DIGITS];
    logic              w_lit;
    logic [NIB_W-1:0]  w_nib;
    logic [3:0]        w_an_on;

    assign w_blank_mask = lz_blank ? lz_mask(r_active) : '0;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign w_dig_nib[k] = r_active[k*NIB_W +: NIB_W];
            assign w_dig_lit[k] = dig_en[k] && !w_blank_mask[k];
        end
    endgenerate

    assign w_lit   = w_dig_lit[w_idx] && w_slot_on;
    assign w_nib   = w_dig_nib[w_idx];
    assign w_an_on = ANODE_OFF & ~(4'b0001 << w_idx);

    logic [3:0] r_nib;
    logic [3:0] r_an;
    logic       r_dp;
    logic       r_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nib        <= 4'h0;
            r_an         <= ANODE_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_nib        <= w_nib;
            r_an         <= w_lit ? w_an_on : ANODE_OFF;
            r_dp         <= w_lit ? ~dp_in[w_idx] : 1'b1;
            r_frame_done <= w_boundary;
        end
    end

    assign nib        = r_nib;
    assign an         = r_an;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_mux
// Description : Directed frame-vector bench for seg_scan_mux (TICK_DIV=8).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg_scan_mux;

    localparam int TICK_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * TICK_DIV;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [15:0] value     = 16'h0000;
    logic        value_vld = 1'b0;
    logic [3:0]  dig_en    = 4'b1111;
    logic        lz_blank  = 1'b0;
    logic [3:0]  dp_in     = 4'b0000;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;

    seg_scan_mux #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .value_vld  (value_vld),
        .dig_en     (dig_en),
        .lz_blank   (lz_blank),
        .dp_in      (dp_in),
        .nib        (nib),
        .an         (an),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected per-slot outputs during the lit part of each slot; index = slot.
    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dig_en;
        logic            lz;
        logic [3:0]      dp_in;
        logic [3:0][3:0] nib;
        logic [3:0][3:0] an;
        logic [3:0]      dp;
    } frame_vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic frame_vec_t mk(input logic [15:0] val, input logic [3:0] en,
                                      input logic lz, input logic [3:0] dpi,
                                      input logic [15:0] nibs, input logic [15:0] ans,
                                      input logic [3:0] dps);
        frame_vec_t v;
        v.value  = val;
        v.dig_en = en;
        v.lz     = lz;
        v.dp_in  = dpi;
        v.nib    = nibs;
        v.an     = ans;
        v.dp     = dps;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got nib=%h an=%b dp=%b fd=%b, want nib=%h an=%b dp=%b fd=%b",
                     name, got[9:6], got[5:2], got[1], got[0],
                     exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one frame, pulsing value_vld mid-frame, ending on the boundary.
    task automatic load(input frame_vec_t v);
        repeat (16) step();
        dig_en    = v.dig_en;
        lz_blank  = v.lz;
        dp_in     = v.dp_in;
        value     = v.value;
        value_vld = 1'b1;
        step();
        value_vld = 1'b0;
        repeat (FRAME - 17) step();
    endtask

    // Checks every cycle of one frame; optional vld pulse sampled at edge pulse_at+1.
    task automatic check_frame(input string tag, input frame_vec_t v,
                               input int pulse_at, input logic [15:0] pulse_val);
        int         slot;
        int         c;
        logic [9:0] exp;
        for (int o = 1; o <= FRAME; o++) begin
            step();
            value_vld = 1'b0;
            slot = (o - 1) / TICK_DIV;
            c    = (o - 1) % TICK_DIV;
            exp[9:6] = v.nib[slot];
            exp[5:2] = (c < BLANK_CYCLES) ? 4'b1111 : v.an[slot];
            exp[1]   = (c < BLANK_CYCLES) ? 1'b1 : v.dp[slot];
            exp[0]   = (o == FRAME);
            cmp($sformatf("%s o=%0d", tag, o), {nib, an, dp, frame_done}, exp);
            if (o == pulse_at) begin
                value     = pulse_val;
                value_vld = 1'b1;
            end
        end
        value_vld = 1'b0;
    endtask

    frame_vec_t tab [5];
    frame_vec_t v_zero;
    frame_vec_t v_1234;
    frame_vec_t v_abcd;
    frame_vec_t v_5555;

    initial begin
        v_zero = mk(16'h0000, 4'b1111, 1'b0, 4'b0000, 16'h0000, 16'b0111_1011_1101_1110, 4'b1111);
        v_1234 = mk(16'h1234, 4'b1111, 1'b0, 4'b0000, 16'h1234, 16'b0111_1011_1101_1110, 4'b1111);
        v_abcd = mk(16'hABCD, 4'b1111, 1'b0, 4'b0000, 16'hABCD, 16'b0111_1011_1101_1110, 4'b1111);
        v_5555 = mk(16'h5555, 4'b1111, 1'b0, 4'b0000, 16'h5555, 16'b0111_1011_1101_1110, 4'b1111);
        tab[0] = v_1234;
        tab[1] = mk(16'h0040, 4'b1111, 1'b1, 4'b0000, 16'h0040, 16'b1111_1111_1101_1110, 4'b1111);
        tab[2] = mk(16'h0000, 4'b1111, 1'b1, 4'b0000, 16'h0000, 16'b1111_1111_1111_1110, 4'b1111);
        tab[3] = mk(16'h1234, 4'b0101, 1'b0, 4'b0100, 16'h1234, 16'b1111_1011_1111_1110, 4'b1011);
        tab[4] = mk(16'h0F00, 4'b1111, 1'b1, 4'b1111, 16'h0F00, 16'b1111_1011_1101_1110, 4'b1000);

        repeat (3) @(negedge clk);
        cmp("reset", {nib, an, dp, frame_done}, {4'h0, 4'b1111, 1'b1, 1'b0});
        rst_n = 1'b1;
        check_frame("post_reset", v_zero, 0, 16'h0000);

        for (int i = 0; i < 5; i++) begin
            load(tab[i]);
            check_frame($sformatf("vec%0d", i), tab[i], 0, 16'h0000);
        end

        load(v_1234);
        check_frame("tear_cur", v_1234, 12, 16'hABCD);
        check_frame("tear_next", v_abcd, FRAME - 1, 16'h5555);
        check_frame("bnd_load", v_5555, 0, 16'h0000);
        check_frame("bnd_hold", v_5555, 0, 16'h0000);

        // Asynchronous reset inside the lit part of the digit-2 slot.
        repeat (19) step();
        cmp("pre_areset", {nib, an, dp, frame_done}, {4'h5, 4'b1011, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 cmp("areset_now", {nib, an, dp, frame_done}, {4'h0, 4'b1111, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp($sformatf("areset_hold%0d", i), {nib, an, dp, frame_done},
                {4'h0, 4'b1111, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        check_frame("after_areset", v_zero, 0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
